// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage plus IF/ID register. Branch redirects resolved in decode
// steer the PC; one architectural delay slot, no flush, decode-issued stall.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'h910003FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_src,
  input  logic        uncond_br,
  input  logic [63:0] br_reg,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [63:0] if_id_pc,
  output logic        if_id_valid
);

  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ifpc_q, ifpc_d;
  logic        vld_q, vld_d;

  // Byte offsets: sign-extend the word offset to 64 bits, then scale by 4.
  function automatic logic signed [63:0] imm26_off(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00};
  endfunction

  function automatic logic signed [63:0] imm19_off(input logic [18:0] imm);
    return {{43{imm[18]}}, imm, 2'b00};
  endfunction

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    vld_d   = vld_q;
    if (!stall) begin
      instr_d = imem_data;
      ifpc_d  = pc_q;
      vld_d   = 1'b1;
      // br_src/uncond_br are only consulted under br_taken so X on them stays out of pc.
      if (br_taken) begin
        if (br_src)
          pc_d = br_reg;
        else if (uncond_br)
          pc_d = ifpc_q + $unsigned(imm26_off(instr_q[25:0]));
        else
          pc_d = ifpc_q + $unsigned(imm19_off(instr_q[23:5]));
      end else begin
        pc_d = pc_q + 64'd4;
      end
    end
  end

  // Fetch / IF-ID register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ifpc_q  <= 64'h0;
      vld_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = vld_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Pipelined fetch stage and IF/ID register for the LEGv8 CPU, sitting directly upstream of the control-signal decoder. It holds the PC, drives the instruction-memory address, and registers the fetched word and its PC into the IF/ID register consumed by decode. It applies branch redirects resolved in decode (BrTaken/BrSrc/UncondBr plus the register operand for BR). The architecture has a single branch-delay slot, and fetch supports a decode-issued stall.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `NOP_WORD`, default 32'h910003FF (ADDI X31, X31, #0): value loaded into the IF/ID instruction register on reset.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `stall`  input  1  hold PC and IF/ID contents this cycle.
- `br_taken`  input  1  decode-stage BrTaken; redirect PC this cycle.
- `br_src`  input  1  decode-stage BrSrc; 1 selects `br_reg`, 0 selects PC-relative target.
- `uncond_br`  input  1  decode-stage UncondBr; 1 selects imm26, 0 selects imm19.
- `br_reg`  input  64  register-file read value used by BR.
- `imem_addr`  output  64  current PC, driven to instruction memory.
- `imem_data`  input  32  instruction word at `imem_addr`; combinational, valid in the same cycle.
- `if_id_instr`  output  32  registered instruction presented to decode.
- `if_id_pc`  output  64  registered PC of `if_id_instr`.
- `if_id_valid`  output  1  1 when `if_id_instr` came from memory; 0 for the reset bubble.

## Operation
- State:
  - `pc` (64b) drives `imem_addr` directly.
  - IF/ID register holds `if_id_instr`, `if_id_pc`, and `if_id_valid`.
- PC-relative target:
  - Base is `if_id_pc`, the PC of the branch now in decode, not the fetch PC.
  - `uncond_br`=1: offset = sign-extend(`if_id_instr[25:0]`) << 2.
  - `uncond_br`=0: offset = sign-extend(`if_id_instr[23:5]`) << 2.
  - Extend to 64 bits before shifting; addition is modulo 2^64.
- Next PC, evaluated in priority order:
  1. `stall`=1: `pc` is held.
  2. `br_taken`=1 and `br_src`=1: `br_reg`, used unmodified with no alignment masking.
  3. `br_taken`=1 and `br_src`=0: PC-relative target.
  4. Otherwise: `pc` + 4, modulo 2^64 (wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0).
- IF/ID update:
  - `stall`=0: `if_id_instr` <= `imem_data`, `if_id_pc` <= `pc`, `if_id_valid` <= 1.
  - `stall`=1: all three are held.
- Delay slot: the instruction fetched in the same cycle a branch is taken in decode is always latched into IF/ID and executes. There is no flush.
- Simultaneous stall and `br_taken`: the stall wins and the redirect is dropped. Decode re-presents the same branch next cycle, because its IF/ID is held.
- `uncond_br` and `br_src` are ignored when `br_taken`=0. X values on them in that case must not propagate to `pc`.

## Timing
- Reset (asynchronous, takes effect without a clock edge):
  - `pc`=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `if_id_instr`=`NOP_WORD`, `if_id_pc`=0, `if_id_valid`=0.
- After reset deasserts:
  - The first rising edge latches `imem_data`@`RESET_PC` into IF/ID and sets `pc`=`RESET_PC`+4.
  - Fetch-to-decode latency is 1 cycle.
- Branch redirect latency:
  - The branch is in decode at cycle N, with `br_taken` sampled at the edge ending N.
  - The delay-slot instruction enters IF/ID at N+1.
  - The target address is on `imem_addr` during N+1.
  - The target instruction enters IF/ID at N+2.
- Stall: while `stall` is high, `imem_addr`, `if_id_*` are constant. Fetch resumes on the first edge with `stall`=0 and no instruction is lost or duplicated.
- Reset asserted mid-stall or mid-branch: the reset values above apply immediately, and any pending redirect is discarded.
- All outputs are registered except `imem_addr`, which is `pc`, also a register output.

## Test plan
- Reset, then 4 free-running cycles with memory word i = 32'h0000_0000 + i:
  - `imem_addr` steps 0, 4, 8, 12.
  - `if_id_pc` steps 0, 4, 8 one cycle behind.
  - `if_id_valid` goes 0 -> 1 after the first edge.
  - During reset, `if_id_instr` = 32'h910003FF.
- B at PC 0x10 (`if_id_instr`=32'h14000004, imm26=+4), `br_taken`=1, `uncond_br`=1, `br_src`=0:
  - The next `imem_addr` is 0x20 (0x10+16), not 0x18.
  - The delay-slot word from 0x14 appears in IF/ID, followed by the word from 0x20.
- CBZ at PC 0x40 with imm19 = -2 (`if_id_instr[23:5]`=19'h7FFFE), `uncond_br`=0, `br_taken`=1: `imem_addr` becomes 0x38.
- BR with `br_taken`=1, `br_src`=1, `br_reg`=64'h0000_0000_0000_0100: `imem_addr`=0x100 next cycle, with `uncond_br`=X having no effect.
- `stall`=1 for 3 cycles at PC 0x8 with `br_taken`=1 asserted concurrently:
  - `imem_addr` stays 0x8 and `if_id_*` stay unchanged.
  - After release, fetch continues at 0xC unless `br_taken` is still high.
- Wrap and reset:
  - With `pc` forced via `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC, the next PC is 0.
  - Asserting `reset` between edges returns `imem_addr` to `RESET_PC` and `if_id_valid` to 0 before the next edge.
